updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down counter with programmable modulus, synchronous clear, parallel load, and wrap or saturate mode at the count limits. It is the general-purpose counting element for datapath controllers, for example iteration and bit-index counters in multiplier/divider control units. Its load/count interface keeps the same port names as the existing counter, so controllers can move to it without renaming signals. It adds down-counting, non-power-of-two moduli, saturation and separate carry/borrow reporting.

## Interface
- `WIDTH`, default 8: counter width in bits; must be ≥ 1.
- `MODULUS`, default 2**WIDTH: count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- `SATURATE`, default 0: 0 = wrap at limits; 1 = hold at limits.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0); release is synchronised externally.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous parallel load of `in`.
- `in`  in  WIDTH  load value.
- `count`  in  1  count enable; advances by one step per cycle.
- `down`  in  1  direction: 0 = increment, 1 = decrement; sampled with `count`.
- `out`  out  WIDTH  registered count value.
- `co`  out  1  registered carry; one-cycle pulse for an up-step at MODULUS-1.
- `bo`  out  1  registered borrow; one-cycle pulse for a down-step at 0.
- `tc`  out  1  combinational terminal count: (`down`==0 && `out`==MODULUS-1) || (`down`==1 && `out`==0).

## Operation
- Reset (`rst`=0): `out`=0, `co`=0, `bo`=0 immediately, independent of `clk`. `tc` then follows its equation (1 if `down`=1).
- Priority per cycle is `clr` > `load` > `count` > hold.
- `clr`=1: `out`←0, `co`←0, `bo`←0.
- `load`=1 (and `clr`=0):
  - `out`←`in` if `in` ≤ MODULUS-1, otherwise `out`←MODULUS-1 (clamp).
  - `co`←0, `bo`←0.
- `count`=1, `down`=0:
  - If `out`<MODULUS-1: `out`←`out`+1.
  - At `out`=MODULUS-1: `out`←0 when SATURATE=0; `out` holds when SATURATE=1. `co`←1 in both modes.
- `count`=1, `down`=1:
  - If `out`>0: `out`←`out`-1.
  - At `out`=0: `out`←MODULUS-1 when SATURATE=0; `out` holds when SATURATE=1. `bo`←1 in both modes.
- In every other case `co`←0 and `bo`←0. Pulses therefore last exactly one cycle per limit event; repeated blocked steps in saturate mode pulse every cycle.
- `co` and `bo` are never high in the same cycle.
- Arithmetic is done in WIDTH+1 bits internally.
- When MODULUS=2**WIDTH, the wrap is the natural overflow: `out` never exceeds MODULUS-1 and the load clamp never triggers.
- A state outside 0..MODULUS-1 is unreachable. No recovery logic is required.

## Timing
- `out`, `co` and `bo` update one cycle after the controlling input is sampled. Latency from `load` or `count` to the new `out` is 1 cycle.
- `co`/`bo` assert in the same cycle that `out` shows the wrapped (or held) value.
- `tc` has zero latency: a controller can qualify a step with `tc` in the current cycle.
- Reset asserted mid-count clears all state asynchronously.
- The first rising edge after reset release with `count`=1 produces `out`=1 (up) or a wrap/saturate to MODULUS-1 / 0 (down).
- `load` and `count` asserted together: the load wins and no pulse is produced.
- Throughput is one step per cycle, with no idle cycles between steps.

## Test plan
Configuration: WIDTH=4, MODULUS=10 unless stated.
- Hold `rst`=0 mid-count at `out`=7 -> `out`=0, `co`=`bo`=0 without a clock edge. Release, then 3 up-counts -> `out`=3.
- SATURATE=0, load 8, then 3 up-counts -> `out`=9, 0, 1. `co`=1 only in the cycle `out`=0. `tc`=1 while `out`=9 and `down`=0.
- SATURATE=0, load 1, then 3 down-counts -> `out`=0, 9, 8. `bo`=1 only in the cycle `out`=9.
- SATURATE=1, load 9, then 3 up-counts -> `out` stays 9 and `co`=1 in each of the 3 cycles. Then 1 down-count -> `out`=8, `co`=0.
- Load 13 -> `out`=9 (clamp). Load 5 with `count`=1 in the same cycle -> `out`=5, no pulse. `clr`=1 with `load`=1 -> `out`=0.
- WIDTH=4, MODULUS=16, SATURATE=0: from 15, up-count -> `out`=0, `co`=1. From 0, down-count -> `out`=15, `bo`=1.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear, clamped load and wrap/saturate at the limits.
// One-cycle latency to out/co/bo; tc is combinational; accepts a step every cycle, no backpressure.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             count,
  input  logic             down,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             bo,
  output logic             tc
);

  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             bo_q, bo_d;

  logic [WIDTH:0] cur_ext;
  logic [WIDTH:0] in_ext;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] dn_diff;
  logic           at_max;
  logic           at_zero;

  // Extra top bit lets a full-range modulus compare and borrow without aliasing.
  assign cur_ext = {1'b0, out_q};
  assign in_ext  = {1'b0, in};
  assign up_sum  = cur_ext + 1'b1;
  assign dn_diff = cur_ext - 1'b1;
  assign at_max  = (up_sum > LIMIT);
  assign at_zero = dn_diff[WIDTH];

  always_comb begin
    out_d = out_q;
    co_d  = 1'b0;
    bo_d  = 1'b0;
    if (clr) begin
      out_d = '0;
    end else if (load) begin
      out_d = (in_ext > LIMIT) ? LIMIT[WIDTH-1:0] : in;
    end else if (count) begin
      if (!down) begin
        if (at_max) begin
          co_d = 1'b1;
          if (!SATURATE) out_d = '0;
        end else begin
          out_d = up_sum[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          bo_d = 1'b1;
          if (!SATURATE) out_d = LIMIT[WIDTH-1:0];
        end else begin
          out_d = dn_diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      co_q  <= 1'b0;
      bo_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      co_q  <= co_d;
      bo_q  <= bo_d;
    end
  end

  assign out = out_q;
  assign co  = co_q;
  assign bo  = bo_q;
  assign tc  = down ? at_zero : at_max;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: three counter variants (mod 10 wrap, mod 10 saturate, mod 16 wrap) on shared inputs.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] in = 4'd0;
  logic       count = 1'b0;
  logic       down = 1'b0;

  logic [3:0] o_w, o_s, o_f;
  logic       co_w, bo_w, tc_w;
  logic       co_s, bo_s, tc_s;
  logic       co_f, bo_f, tc_f;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .count(count), .down(down),
    .out(o_w), .co(co_w), .bo(bo_w), .tc(tc_w)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .count(count), .down(down),
    .out(o_s), .co(co_s), .bo(bo_s), .tc(tc_s)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .count(count), .down(down),
    .out(o_f), .co(co_f), .bo(bo_f), .tc(tc_f)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Apply one cycle of inputs, then land 1 time unit after the rising edge.
  task automatic step(input logic c, input logic l, input logic [3:0] v,
                      input logic cn, input logic dn);
    clr = c; load = l; in = v; count = cn; down = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_out", o_w, 0);
    chk("rst_co", co_w, 0);
    chk("rst_bo", bo_w, 0);
    chk("rst_tc_up", tc_w, 0);
    down = 1'b1;
    #1;
    chk("rst_tc_dn", tc_w, 1);
    down = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Async reset in the middle of a count
    step(0, 1, 4'd6, 0, 0);
    step(0, 0, 4'd0, 1, 0);
    chk("pre_rst_out", o_w, 7);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", o_w, 0);
    chk("async_rst_co", co_w, 0);
    chk("async_rst_bo", bo_w, 0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 4'd0, 1, 0);
    chk("post_rst_up1", o_w, 1);
    step(0, 0, 4'd0, 1, 0);
    step(0, 0, 4'd0, 1, 0);
    chk("post_rst_up3", o_w, 3);

    // Wrap up through 9
    step(0, 1, 4'd8, 0, 0);
    chk("ld8", o_w, 8);
    step(0, 0, 4'd0, 1, 0);
    chk("up_9", o_w, 9);
    chk("up_9_co", co_w, 0);
    chk("tc_at_9", tc_w, 1);
    step(0, 0, 4'd0, 1, 0);
    chk("wrap_0", o_w, 0);
    chk("wrap_0_co", co_w, 1);
    chk("wrap_0_bo", bo_w, 0);
    chk("tc_at_0_up", tc_w, 0);
    step(0, 0, 4'd0, 1, 0);
    chk("up_1", o_w, 1);
    chk("up_1_co", co_w, 0);

    // Wrap down through 0
    step(0, 1, 4'd1, 0, 0);
    step(0, 0, 4'd0, 1, 1);
    chk("dn_0", o_w, 0);
    chk("dn_0_bo", bo_w, 0);
    chk("tc_at_0_dn", tc_w, 1);
    step(0, 0, 4'd0, 1, 1);
    chk("wrap_9", o_w, 9);
    chk("wrap_9_bo", bo_w, 1);
    chk("wrap_9_co", co_w, 0);
    step(0, 0, 4'd0, 1, 1);
    chk("dn_8", o_w, 8);
    chk("dn_8_bo", bo_w, 0);

    // Saturate at the top
    step(0, 1, 4'd9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'd0, 1, 0);
      chk($sformatf("sat_hold_%0d", i), o_s, 9);
      chk($sformatf("sat_co_%0d", i), co_s, 1);
    end
    step(0, 0, 4'd0, 1, 1);
    chk("sat_dn_8", o_s, 8);
    chk("sat_dn_co", co_s, 0);
    chk("sat_dn_bo", bo_s, 0);

    // Saturate at the bottom
    step(0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 1, 1);
    chk("sat_hold_0", o_s, 0);
    chk("sat_bo", bo_s, 1);

    // Load clamp, load-over-count, clear-over-load
    step(0, 1, 4'd13, 0, 0);
    chk("clamp_w", o_w, 9);
    chk("clamp_s", o_s, 9);
    chk("noclamp_full", o_f, 13);
    step(0, 1, 4'd5, 1, 0);
    chk("ld_cnt_out", o_w, 5);
    chk("ld_cnt_co", co_w, 0);
    chk("ld_cnt_bo", bo_w, 0);
    step(1, 1, 4'd7, 1, 0);
    chk("clr_ld_out", o_w, 0);

    // Full-range modulus wraps naturally
    step(0, 1, 4'd15, 0, 0);
    chk("full_ld15", o_f, 15);
    chk("full_tc15", tc_f, 1);
    step(0, 0, 4'd0, 1, 0);
    chk("full_wrap0", o_f, 0);
    chk("full_co", co_f, 1);
    step(0, 0, 4'd0, 1, 1);
    chk("full_wrap15", o_f, 15);
    chk("full_bo", bo_f, 1);
    chk("full_co_clr", co_f, 0);
    step(0, 0, 4'd0, 0, 0);
    chk("full_hold", o_f, 15);
    chk("full_bo_clr", bo_f, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
